sobel_window_buffer: RTL and testbench
======================================

// Module: sobel_window_buffer
// PURPOSE
//  Producer side of the 3x3 window interface consumed by the Sobel gradient blocks.
//  - Accepts a raster-order 8-bit pixel stream and stores the two previous rows in line buffers.
//  - Emits one 3x3 window per interior pixel, with a valid/ready handshake.
//  - window/win_valid drive windowBuffer/start_calculations of the gradient stage.
// PARAMETERS
//  IMG_WIDTH   640  pixels per row (>=3)
//  IMG_HEIGHT  480  rows per frame (>=3)
// PORTS
//  clk        in   1        system clock, all logic posedge
//  rst        in   1        synchronous reset, active-high
//  pix_in     in   8        pixel data, raster order
//  pix_valid  in   1        pix_in valid
//  pix_sof    in   1        marks first pixel of frame; qualified by pix_valid
//  pix_ready  out  1        block accepts pix_in this cycle
//  window     out  8 x [0:8] 3x3 window, row-major; [0..2]=oldest row, [6..8]=newest row
//  win_valid  out  1        window valid (drives start_calculations)
//  win_ready  in   1        consumer takes window this cycle
// BEHAVIOUR
//  - Reset (sync, active-high, one clk): col=0, row=0, win_valid=0, window all 0x00, pix_ready=1.
//    Line-buffer RAM is not reset; stale contents are masked by the row>=2 rule.
//  - Handshake:
//    - pix_ready = !win_valid || win_ready (combinational); accept = pix_valid && pix_ready.
//    - window and win_valid stay stable while win_valid && !win_ready.
//  - On accept at (row,col):
//    - Read lb_old[col] (row-2) and lb_new[col] (row-1), then write lb_old[col]<=lb_new[col],
//      lb_new[col]<=pix_in (read-before-write, same address).
//    - Shift the 3x3 column register left by one column; new right column = {lb_old, lb_new, pix_in}.
//  - Emit: if row>=2 && col>=2, window<=shifted register and win_valid<=1 next cycle
//    (latency 1 clk from accept). Window is centred on (row-1,col-1).
//    - Else, on a cycle where win_ready is taken, win_valid<=0.
//  - Counters: col wraps IMG_WIDTH-1 -> 0 with row++; after (IMG_HEIGHT-1, IMG_WIDTH-1), row=col=0.
//    Width $clog2 of each dimension.
//  - pix_sof accepted: pixel treated as (0,0) regardless of counters (mid-frame resync).
//    Prior-frame rows are never emitted.
//  - Windows per frame: (IMG_WIDTH-2)*(IMG_HEIGHT-2); no border windows, no padding.
//  - Same-cycle accept and win_ready: old window consumed, new window loaded; no bubble.
//    Full throughput is 1 pixel/clk.
//  - rst mid-operation: pending window is dropped (win_valid=0 next cycle); counters return to (0,0).
// CONFIGURATION
//  SOBEL_WIN_STATS_EN defined:
//  - Adds out frame_done (1-clk pulse when the last window of a frame is accepted by the consumer).
//  - Adds out win_count [$clog2((IMG_WIDTH-2)*(IMG_HEIGHT-2)+1)-1:0]:
//    - counts windows handed off this frame;
//    - clears on rst or accepted pix_sof;
//    - holds its final value until the next frame's first window.
//  SOBEL_WIN_STATS_EN undefined: the ports and logic are absent; behaviour otherwise identical.
// STRUCTURE
//  - sobel_pkg:
//    - PIX_W=8;
//    - typedef logic [PIX_W-1:0] window_t [0:8];
//    - tap index constants WIN_TL..WIN_BR (0..8).
//  - Sub-module sobel_line_buffer (DEPTH=IMG_WIDTH, 8-bit, one read and one write at the same
//    address, read-before-write, no reset), instantiated twice (lb_old, lb_new).
//  - Counters, column shift register and output stage live in the top.
// TESTING  (bench params IMG_WIDTH=5, IMG_HEIGHT=4, pix = row*16+col)
//  1. rst=1 two clks -> win_valid=0, window all 0x00, pix_ready=1.
//  2. One frame, sof on the first pixel, win_ready=1 -> exactly 6 windows.
//     - First window one clk after (2,2) is accepted: {00,01,02,10,11,12,20,21,22}.
//     - Last window: {12,13,14,22,23,24,32,33,34}.
//  3. win_ready=0 for 3 clks during the first window -> pix_ready=0 and window stable.
//     After release, the remaining windows are unchanged; total still 6.
//  4. sof reasserted at old (1,3) -> no window until new (2,2); first window has 0x00 top-left.
//  5. Two back-to-back frames, pix_valid=1 continuously -> 12 windows, one per clk when in range.
//     No window contains first-frame data after the second sof.
//  6. rst pulsed at (2,3) while win_valid=1 -> win_valid=0 next clk.
//     Restarted frame gives its first window after (2,2); with SOBEL_WIN_STATS_EN, win_count=0
//     after reset and frame_done pulses once per completed frame.

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared types for the Sobel window path: pixel width, the 3x3 window type and its tap indices.
package sobel_pkg;
  localparam int PIX_W = 8;

  typedef logic [PIX_W-1:0] window_t [0:8];

  localparam int WIN_TL = 0;
  localparam int WIN_TC = 1;
  localparam int WIN_TR = 2;
  localparam int WIN_ML = 3;
  localparam int WIN_MC = 4;
  localparam int WIN_MR = 5;
  localparam int WIN_BL = 6;
  localparam int WIN_BC = 7;
  localparam int WIN_BR = 8;
endpackage

// File: rtl/sobel_line_buffer.sv
// One-row pixel store: asynchronous read and synchronous write at the same address.
// A read in the write cycle returns the old contents. The array has no reset.
module sobel_line_buffer import sobel_pkg::*; #(
  parameter int DEPTH = 640,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [PIX_W-1:0] wdata,
  output logic [PIX_W-1:0] rdata
);
  logic [PIX_W-1:0] mem_q [0:DEPTH-1];

  assign rdata = mem_q[addr];

  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
  end
endmodule

// File: rtl/sobel_window_buffer.sv
// Builds 3x3 windows from a raster pixel stream using two line buffers. It emits one window per interior pixel.
// Defining SOBEL_WIN_STATS_EN adds the frame_done and win_count outputs.
module sobel_window_buffer import sobel_pkg::*; #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             pix_valid,
  input  logic             pix_sof,
  output logic             pix_ready,
  output window_t          window,
  output logic             win_valid,
  input  logic             win_ready
`ifdef SOBEL_WIN_STATS_EN
  ,
  output logic             frame_done,
  output logic [$clog2((IMG_WIDTH-2)*(IMG_HEIGHT-2)+1)-1:0] win_count
`endif
);
  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int ROW_W = $clog2(IMG_HEIGHT);
  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_FIRST = COL_W'(2);
  localparam logic [ROW_W-1:0] ROW_FIRST = ROW_W'(2);

  logic [COL_W-1:0] col_q, col_d, cur_col;
  logic [ROW_W-1:0] row_q, row_d, cur_row;
  window_t          col_reg_q, col_reg_d, window_q, window_d;
  logic             win_valid_q, win_valid_d;
  logic             accept, handoff;
  logic [PIX_W-1:0] lb_old_rd, lb_new_rd;

  // Valid/ready: a transfer happens on a cycle where valid and ready are both high.
  // The producer holds data while it is stalled. A window can be replaced in the cycle it is consumed.
  assign pix_ready = !win_valid_q || win_ready;
  assign accept    = pix_valid && pix_ready;
  assign handoff   = win_valid_q && win_ready;
  assign cur_col   = pix_sof ? '0 : col_q;
  assign cur_row   = pix_sof ? '0 : row_q;

  sobel_line_buffer #(.DEPTH(IMG_WIDTH), .AW(COL_W)) u_lb_old (
    .clk(clk), .we(accept), .addr(cur_col), .wdata(lb_new_rd), .rdata(lb_old_rd)
  );

  sobel_line_buffer #(.DEPTH(IMG_WIDTH), .AW(COL_W)) u_lb_new (
    .clk(clk), .we(accept), .addr(cur_col), .wdata(pix_in), .rdata(lb_new_rd)
  );

  always_comb begin
    col_reg_d   = col_reg_q;
    window_d    = window_q;
    win_valid_d = win_valid_q;
    col_d       = col_q;
    row_d       = row_q;
    if (handoff) win_valid_d = 1'b0;
    if (accept) begin
      for (int i = 0; i < 3; i++) begin
        col_reg_d[3*i]   = col_reg_q[3*i+1];
        col_reg_d[3*i+1] = col_reg_q[3*i+2];
      end
      col_reg_d[WIN_TR] = lb_old_rd;
      col_reg_d[WIN_MR] = lb_new_rd;
      col_reg_d[WIN_BR] = pix_in;
      if (cur_row >= ROW_FIRST && cur_col >= COL_FIRST) begin
        window_d    = col_reg_d;
        win_valid_d = 1'b1;
      end
      if (cur_col == COL_LAST) begin
        col_d = '0;
        row_d = (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
      end else begin
        col_d = cur_col + 1'b1;
        row_d = cur_row;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q       <= '0;
      row_q       <= '0;
      col_reg_q   <= '{default: '0};
      window_q    <= '{default: '0};
      win_valid_q <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      col_reg_q   <= col_reg_d;
      window_q    <= window_d;
      win_valid_q <= win_valid_d;
    end
  end

  assign window    = window_q;
  assign win_valid = win_valid_q;

`ifdef SOBEL_WIN_STATS_EN
  localparam int WIN_TOTAL = (IMG_WIDTH-2)*(IMG_HEIGHT-2);
  localparam int CNT_W     = $clog2(WIN_TOTAL+1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIN_TOTAL);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIN_TOTAL - 1);

  logic [CNT_W-1:0] win_count_q, win_count_d;
  logic             frame_done_q, frame_done_d;

  // A full count stays visible until the next frame's first handoff restarts it at 1.
  always_comb begin
    win_count_d  = win_count_q;
    frame_done_d = 1'b0;
    if (handoff) begin
      frame_done_d = (win_count_q == CNT_LAST);
      win_count_d  = (win_count_q == CNT_FULL) ? CNT_W'(1) : win_count_q + 1'b1;
    end
    if (accept && pix_sof) win_count_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win_count_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      win_count_q  <= win_count_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign win_count  = win_count_q;
  assign frame_done = frame_done_q;
`endif
endmodule

// File: tb/tb_sobel_window_buffer.sv
// Bench for sobel_window_buffer on a 5x4 image. An image-array reference model fills an expected-window queue.
// It also builds with SOBEL_WIN_STATS_EN defined.
module tb_sobel_window_buffer;
  import sobel_pkg::*;

  localparam int W = 5;
  localparam int H = 4;
  localparam logic [71:0] FIRST_WIN  = {8'h00, 8'h01, 8'h02, 8'h10, 8'h11, 8'h12, 8'h20, 8'h21, 8'h22};
  localparam logic [71:0] SECOND_WIN = {8'h01, 8'h02, 8'h03, 8'h11, 8'h12, 8'h13, 8'h21, 8'h22, 8'h23};
  localparam logic [71:0] LAST_WIN   = {8'h12, 8'h13, 8'h14, 8'h22, 8'h23, 8'h24, 8'h32, 8'h33, 8'h34};

  logic       clk = 1'b0;
  logic       rst, pix_valid, pix_sof, win_ready, pix_ready, win_valid;
  logic [7:0] pix_in;
  window_t    window;
`ifdef SOBEL_WIN_STATS_EN
  logic       frame_done;
  logic [2:0] win_count;
`endif

  sobel_window_buffer #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid), .pix_sof(pix_sof),
    .pix_ready(pix_ready), .window(window), .win_valid(win_valid), .win_ready(win_ready)
`ifdef SOBEL_WIN_STATS_EN
    , .frame_done(frame_done), .win_count(win_count)
`endif
  );

  // Clock/reset block
  always #5 clk = ~clk;

  // Scoreboard state and reference model
  int          checks = 0;
  int          errors = 0;
  logic [71:0] exp_q[$];
  bit          last_q[$];
  logic [71:0] got_log[$];
  logic [7:0]  img [0:H-1][0:W-1];
  int          mr, mc;
  int          handed;
  int          stall_left;
  int          wc_exp;
  bit          wc_restart;
  bit          fd_exp;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [71:0] pack_win(input window_t wv);
    logic [71:0] r;
    for (int i = 0; i < 9; i++) r[71-8*i -: 8] = wv[i];
    return r;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    last_q.delete();
    mr = 0; mc = 0;
    wc_exp = 0; wc_restart = 0; fd_exp = 0;
  endtask

  // Reference model: the image is stored as a 2-D array. An interior pixel yields the 3x3 neighbourhood ending at it.
  task automatic model_accept(input bit s, input logic [7:0] p);
    logic [71:0] e;
    int k;
    if (s) begin
      mr = 0; mc = 0; wc_exp = 0; wc_restart = 0;
    end
    img[mr][mc] = p;
    if (mr >= 2 && mc >= 2) begin
      k = 0;
      for (int dr = -2; dr <= 0; dr++)
        for (int dc = -2; dc <= 0; dc++) begin
          e[71-8*k -: 8] = img[mr+dr][mc+dc];
          k++;
        end
      exp_q.push_back(e);
      last_q.push_back(mr == H-1 && mc == W-1);
    end
    mc++;
    if (mc == W) begin
      mc = 0;
      mr++;
      if (mr == H) mr = 0;
    end
  endtask

  // Driver: one clock cycle. The task starts at the negedge, checks outputs, updates the model and returns at the next negedge.
  task automatic step(input bit v, input bit s, input logic [7:0] p, input bit w, output bit acc);
    bit pend, exp_rdy, lastb;
    pix_valid = v; pix_sof = s; pix_in = p; win_ready = w;
    #1;
    pend    = (exp_q.size() != 0);
    exp_rdy = !pend || w;
    chk("win_valid", 72'(win_valid), 72'(pend));
    chk("pix_ready", 72'(pix_ready), 72'(exp_rdy));
    if (pend) chk("window", pack_win(window), exp_q[0]);
`ifdef SOBEL_WIN_STATS_EN
    chk("win_count", 72'(win_count), 72'(wc_exp));
    chk("frame_done", 72'(frame_done), 72'(fd_exp));
`endif
    fd_exp = 0;
    if (pend && w) begin
      got_log.push_back(pack_win(window));
      void'(exp_q.pop_front());
      lastb = last_q.pop_front();
      handed++;
      wc_exp = wc_restart ? 1 : wc_exp + 1;
      wc_restart = lastb;
      fd_exp = lastb;
    end
    acc = v && exp_rdy;
    if (acc) model_accept(s, p);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; pix_valid = 1'b0; pix_sof = 1'b0; win_ready = 1'b0;
    repeat (n) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    chk("rst_win_valid", 72'(win_valid), 72'(0));
    chk("rst_window", pack_win(window), 72'(0));
    chk("rst_pix_ready", 72'(pix_ready), 72'(1));
`ifdef SOBEL_WIN_STATS_EN
    chk("rst_win_count", 72'(win_count), 72'(0));
    chk("rst_frame_done", 72'(frame_done), 72'(0));
`endif
  endtask

  function automatic bit pick_ready(input int rmode);
    if (rmode == 1) return 1'($urandom_range(0, 1));
    if (rmode == 2 && exp_q.size() != 0 && stall_left > 0) begin
      stall_left--;
      return 1'b0;
    end
    return 1'b1;
  endfunction

  // Sends n pixels starting at raster position (r0,c0). The value is row*16+col xor xv, or random if rnd is set.
  task automatic send(input int r0, input int c0, input int n, input bit sof_first,
                      input logic [7:0] xv, input bit rnd, input bit vrand, input int rmode);
    int r, c, tries;
    bit acc, first, v, w;
    logic [7:0] p;
    r = r0; c = c0; first = 1'b1;
    for (int i = 0; i < n; i++) begin
      p = rnd ? 8'($urandom_range(0, 255)) : (8'(r*16 + c) ^ xv);
      acc = 1'b0;
      tries = 0;
      while (!acc && tries < 200) begin
        v = vrand ? ($urandom_range(0, 3) != 0) : 1'b1;
        w = pick_ready(rmode);
        step(v, first && sof_first && v, p, w, acc);
        tries++;
      end
      if (!acc) begin
        checks++;
        errors++;
        $error("FAIL accept_timeout observed=%0d expected=<200", tries);
      end
      first = 1'b0;
      c++;
      if (c == W) begin
        c = 0;
        r++;
        if (r == H) r = 0;
      end
    end
  endtask

  task automatic drain(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 1'b1, acc);
  endtask

  initial begin
    rst = 1'b1; pix_valid = 1'b0; pix_sof = 1'b0; pix_in = '0; win_ready = 1'b0;
    stall_left = 0; handed = 0;
    model_reset();
    @(negedge clk);

    // Reset state
    do_reset(2);

    // One frame with the consumer always ready
    handed = 0; got_log.delete();
    send(0, 0, W*H, 1'b1, 8'h00, 1'b0, 1'b0, 0);
    drain(3);
    chk("t2_count", 72'(handed), 72'(6));
    chk("t2_first", got_log[0], FIRST_WIN);
    chk("t2_last", got_log[5], LAST_WIN);

    // Consumer stalls for 3 cycles on the first window
    handed = 0; got_log.delete(); stall_left = 3;
    send(0, 0, W*H, 1'b1, 8'h00, 1'b0, 1'b0, 2);
    drain(3);
    chk("t3_count", 72'(handed), 72'(6));
    chk("t3_first", got_log[0], FIRST_WIN);
    chk("t3_second", got_log[1], SECOND_WIN);
    chk("t3_last", got_log[5], LAST_WIN);

    // Mid-frame resync: sof arrives where (1,3) would have been
    handed = 0; got_log.delete();
    send(0, 0, 8, 1'b1, 8'h55, 1'b0, 1'b0, 0);
    chk("t4_no_early", 72'(handed), 72'(0));
    send(0, 0, W*H, 1'b1, 8'h00, 1'b0, 1'b0, 0);
    drain(3);
    chk("t4_count", 72'(handed), 72'(6));
    chk("t4_topleft", 72'(got_log[0][71:64]), 72'(0));
    chk("t4_first", got_log[0], FIRST_WIN);

    // Two back-to-back frames with continuous valid
    handed = 0; got_log.delete();
    send(0, 0, W*H, 1'b1, 8'h00, 1'b0, 1'b0, 0);
    send(0, 0, W*H, 1'b1, 8'h80, 1'b0, 1'b0, 0);
    drain(3);
    chk("t5_count", 72'(handed), 72'(12));
    chk("t5_f2_first", got_log[6], FIRST_WIN ^ {9{8'h80}});

    // Reset while a window is pending
    handed = 0; got_log.delete();
    send(0, 0, 13, 1'b1, 8'h00, 1'b0, 1'b0, 0);
    pix_in = 8'h23;
    do_reset(1);
    send(0, 0, W*H, 1'b1, 8'h00, 1'b0, 1'b0, 0);
    drain(3);
    chk("t6_count", 72'(handed), 72'(6));
    chk("t6_first", got_log[0], FIRST_WIN);

    // Random pixels, valid gaps and backpressure, with a partial frame and one frame without sof
    handed = 0; got_log.delete();
    send(0, 0, 11, 1'b1, 8'h00, 1'b1, 1'b1, 1);
    send(0, 0, W*H, 1'b1, 8'h00, 1'b1, 1'b1, 1);
    send(0, 0, W*H, 1'b0, 8'h00, 1'b1, 1'b1, 1);
    send(0, 0, W*H, 1'b1, 8'h00, 1'b1, 1'b1, 1);
    send(0, 0, W*H, 1'b1, 8'h00, 1'b1, 1'b1, 1);
    drain(5);
    chk("t7_count", 72'(handed), 72'(24));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
